guess_game_ctrl: RTL and testbench

Sequencer for one round of the 4-digit code-breaking game. It latches the secret answer and assembles the player's guess one digit at a time. It presents both to the check_guess datapath, waits out that block's one-cycle registered latency, then captures its {wrong, correct} result. It counts attempts and declares win or lose; the display and input-debounce logic sit around it.

---
 rtl/guess_game_ctrl.sv | 153 +++++++++++++++
 tb/tb_guess_game_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Round sequencer for the 4-digit code-breaking game: latches the answer, assembles the guess,
// waits out the check_guess register stage and scores the attempt.
module guess_game_ctrl #(
  parameter int unsigned MAX_TRIES = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_secret_in,
  input  logic        i_digit_valid,
  input  logic [3:0]  i_digit,
  input  logic        i_clear,
  input  logic [7:0]  i_result,
  output logic [15:0] o_answer_out,
  output logic [15:0] o_guess_out,
  output logic [2:0]  o_digit_count,
  output logic [3:0]  o_attempts,
  output logic [3:0]  o_last_correct,
  output logic [3:0]  o_last_wrong,
  output logic        o_result_valid,
  output logic        o_digit_err,
  output logic        o_win,
  output logic        o_lose,
  output logic        o_busy
);

  localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

  typedef enum logic [2:0] {StIdle, StEntry, StWait, StEval, StWin, StLose} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_answer, w_answer_d;
  logic [15:0] r_guess, w_guess_d;
  logic [2:0]  r_count, w_count_d;
  logic [3:0]  r_attempts, w_attempts_d;
  logic [3:0]  r_last_correct, w_last_correct_d;
  logic [3:0]  r_last_wrong, w_last_wrong_d;
  logic        r_result_valid, w_result_valid_d;
  logic        r_digit_err, w_digit_err_d;
  logic        r_win, r_lose, r_busy;

  logic       w_digit_legal;
  logic [3:0] w_attempts_inc;

  assign w_digit_legal  = i_digit <= 4'd9;
  assign w_attempts_inc = r_attempts + 4'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_answer       <= '0;
      r_guess        <= '0;
      r_count        <= '0;
      r_attempts     <= '0;
      r_last_correct <= '0;
      r_last_wrong   <= '0;
      r_result_valid <= 1'b0;
      r_digit_err    <= 1'b0;
      r_win          <= 1'b0;
      r_lose         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_answer       <= w_answer_d;
      r_guess        <= w_guess_d;
      r_count        <= w_count_d;
      r_attempts     <= w_attempts_d;
      r_last_correct <= w_last_correct_d;
      r_last_wrong   <= w_last_wrong_d;
      r_result_valid <= w_result_valid_d;
      r_digit_err    <= w_digit_err_d;
      // Status flags follow the next state so they are registered yet track the state exactly.
      r_win          <= (w_state_d == StWin);
      r_lose         <= (w_state_d == StLose);
      r_busy         <= (w_state_d == StEntry) || (w_state_d == StWait) || (w_state_d == StEval);
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StWin, StLose: if (i_start) w_state_d = StEntry;
      StEntry: begin
        if (!i_clear && i_digit_valid && w_digit_legal && (r_count == 3'd3)) w_state_d = StWait;
      end
      StWait: w_state_d = StEval;
      StEval: begin
        // A full match wins even on the last allowed attempt.
        if (i_result[3:0] == 4'd4)           w_state_d = StWin;
        else if (w_attempts_inc == MaxTries) w_state_d = StLose;
        else                                 w_state_d = StEntry;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_answer_d       = r_answer;
    w_guess_d        = r_guess;
    w_count_d        = r_count;
    w_attempts_d     = r_attempts;
    w_last_correct_d = r_last_correct;
    w_last_wrong_d   = r_last_wrong;
    w_result_valid_d = 1'b0;
    w_digit_err_d    = 1'b0;
    unique case (r_state)
      StIdle, StWin, StLose: begin
        if (i_start) begin
          w_answer_d       = i_secret_in;
          w_guess_d        = '0;
          w_count_d        = '0;
          w_attempts_d     = '0;
          w_last_correct_d = '0;
          w_last_wrong_d   = '0;
        end
      end
      StEntry: begin
        if (i_clear) begin
          w_guess_d = '0;
          w_count_d = '0;
        end else if (i_digit_valid) begin
          if (w_digit_legal) begin
            w_guess_d = {r_guess[11:0], i_digit};
            w_count_d = r_count + 3'd1;
          end else begin
            w_digit_err_d = 1'b1;
          end
        end
      end
      StEval: begin
        w_last_correct_d = i_result[3:0];
        w_last_wrong_d   = i_result[7:4];
        w_attempts_d     = w_attempts_inc;
        w_result_valid_d = 1'b1;
        w_count_d        = '0;
      end
      default: ;
    endcase
  end

  assign o_answer_out   = r_answer;
  assign o_guess_out    = r_guess;
  assign o_digit_count  = r_count;
  assign o_attempts     = r_attempts;
  assign o_last_correct = r_last_correct;
  assign o_last_wrong   = r_last_wrong;
  assign o_result_valid = r_result_valid;
  assign o_digit_err    = r_digit_err;
  assign o_win          = r_win;
  assign o_lose         = r_lose;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Randomized scoreboard bench for guess_game_ctrl with a round-level reference model and a
// behavioural check_guess stand-in.
module tb_guess_game_ctrl;

  localparam int MT = 3;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_start = 1'b0, i_digit_valid = 1'b0, i_clear = 1'b0;
  logic [15:0] i_secret_in = '0;
  logic [3:0]  i_digit = '0;
  logic [7:0]  i_result;
  logic [15:0] o_answer_out, o_guess_out;
  logic [2:0]  o_digit_count;
  logic [3:0]  o_attempts, o_last_correct, o_last_wrong;
  logic        o_result_valid, o_digit_err, o_win, o_lose, o_busy;

  guess_game_ctrl #(.MAX_TRIES(MT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_secret_in(i_secret_in),
    .i_digit_valid(i_digit_valid), .i_digit(i_digit), .i_clear(i_clear), .i_result(i_result),
    .o_answer_out(o_answer_out), .o_guess_out(o_guess_out), .o_digit_count(o_digit_count),
    .o_attempts(o_attempts), .o_last_correct(o_last_correct), .o_last_wrong(o_last_wrong),
    .o_result_valid(o_result_valid), .o_digit_err(o_digit_err), .o_win(o_win),
    .o_lose(o_lose), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Mastermind scoring: exact positions, plus shared digits in the wrong place.
  function automatic logic [7:0] score(input logic [15:0] a, input logic [15:0] g);
    int c = 0;
    int common = 0;
    int ca[10];
    int cg[10];
    for (int k = 0; k < 10; k++) begin
      ca[k] = 0;
      cg[k] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (a[i*4 +: 4] == g[i*4 +: 4]) c++;
      if (a[i*4 +: 4] < 4'd10) ca[a[i*4 +: 4]]++;
      if (g[i*4 +: 4] < 4'd10) cg[g[i*4 +: 4]]++;
    end
    for (int k = 0; k < 10; k++) common += (ca[k] < cg[k]) ? ca[k] : cg[k];
    return {4'(common - c), 4'(c)};
  endfunction

  // check_guess stand-in: one registered stage, reset by the same net.
  logic [7:0] r_cg;
  always @(posedge clk) begin
    if (i_reset) r_cg <= '0;
    else         r_cg <= score(o_answer_out, o_guess_out);
  end
  assign i_result = r_cg;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  lc;
    logic [3:0]  lw;
    logic [3:0]  att;
    logic [15:0] guess;
    logic        win;
    logic        lose;
  } exp_t;
  exp_t sb[$];

  // Monitor: every result_valid pulse must match the oldest expected check outcome.
  always @(negedge clk) begin
    if (o_result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_rv: got 1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_last_correct", 16'(o_last_correct), 16'(e.lc));
        chk("sb_last_wrong", 16'(o_last_wrong), 16'(e.lw));
        chk("sb_attempts", 16'(o_attempts), 16'(e.att));
        chk("sb_guess", o_guess_out, e.guess);
        chk("sb_win", 16'(o_win), 16'(e.win));
        chk("sb_lose", 16'(o_lose), 16'(e.lose));
      end
    end
  end

  // Reference model at round level.
  bit          m_round_on = 0;
  int          m_pending = 0;
  int          m_outcome = 0;
  logic [15:0] m_secret = '0;
  int          gw[$] = '{0, 0, 0, 0};
  int          m_count = 0, m_attempts = 0, m_lc = 0, m_lw = 0;

  function automatic logic [15:0] gword();
    return {4'(gw[0]), 4'(gw[1]), 4'(gw[2]), 4'(gw[3])};
  endfunction

  task automatic step(input bit st, input logic [15:0] sec, input bit dv, input logic [3:0] d,
                      input bit clr, input bit rst);
    bit exp_err = 0;
    bit exp_rv = 0;
    i_start = st; i_secret_in = sec; i_digit_valid = dv; i_digit = d; i_clear = clr;
    i_reset = rst;
    @(posedge clk);
    #1;
    i_start = 0; i_digit_valid = 0; i_clear = 0; i_reset = 0;
    if (rst) begin
      m_round_on = 0; m_pending = 0; m_outcome = 0; m_secret = '0; gw = '{0, 0, 0, 0};
      m_count = 0; m_attempts = 0; m_lc = 0; m_lw = 0;
      sb.delete();
    end else if (m_pending > 0) begin
      m_pending--;
      if (m_pending == 0) begin
        logic [7:0] s;
        s = score(m_secret, gword());
        m_attempts++;
        m_lc = int'(s[3:0]);
        m_lw = int'(s[7:4]);
        m_count = 0;
        exp_rv = 1;
        if (m_lc == 4) begin
          m_outcome = 1; m_round_on = 0;
        end else if (m_attempts == MT) begin
          m_outcome = 2; m_round_on = 0;
        end
      end
    end else if (!m_round_on) begin
      if (st) begin
        m_secret = sec; gw = '{0, 0, 0, 0}; m_count = 0; m_attempts = 0;
        m_lc = 0; m_lw = 0; m_outcome = 0; m_round_on = 1;
      end
    end else if (clr) begin
      gw = '{0, 0, 0, 0};
      m_count = 0;
    end else if (dv) begin
      if (d <= 4'd9) begin
        gw.push_back(int'(d));
        void'(gw.pop_front());
        m_count++;
        if (m_count == 4) begin
          exp_t e;
          logic [7:0] s;
          s = score(m_secret, gword());
          e.lc = s[3:0]; e.lw = s[7:4]; e.att = 4'(m_attempts + 1); e.guess = gword();
          e.win = (s[3:0] == 4'd4);
          e.lose = (s[3:0] != 4'd4) && (m_attempts + 1 == MT);
          sb.push_back(e);
          m_pending = 2;
        end
      end else begin
        exp_err = 1;
      end
    end
    chk("busy", 16'(o_busy), 16'(m_round_on));
    chk("win", 16'(o_win), 16'(m_outcome == 1));
    chk("lose", 16'(o_lose), 16'(m_outcome == 2));
    chk("digit_count", 16'(o_digit_count), 16'(m_count));
    chk("attempts", 16'(o_attempts), 16'(m_attempts));
    chk("last_correct", 16'(o_last_correct), 16'(m_lc));
    chk("last_wrong", 16'(o_last_wrong), 16'(m_lw));
    chk("digit_err", 16'(o_digit_err), 16'(exp_err));
    chk("result_valid", 16'(o_result_valid), 16'(exp_rv));
    chk("answer_out", o_answer_out, m_secret);
    chk("guess_out", o_guess_out, gword());
  endtask

  task automatic key(input logic [3:0] d);
    step(0, '0, 1, d, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0);
  endtask

  task automatic start(input logic [15:0] sec);
    step(1, sec, 0, '0, 0, 0);
  endtask

  task automatic guess4(input logic [15:0] g);
    for (int i = 3; i >= 0; i--) key(g[i*4 +: 4]);
  endtask

  initial begin
    step(0, '0, 0, '0, 0, 1);
    // Win on first try, then a full-miss permutation.
    start(16'h1234); guess4(16'h1234); idle(3);
    chk("tp_win", 16'(o_win), 16'd1);
    start(16'h1234); guess4(16'h4321); idle(3);
    chk("tp_perm_wrong", 16'(o_last_wrong), 16'd4);
    start(16'h5678);
    chk("tp_start_ignored", o_answer_out, 16'h1234);
    // Exhaust the try limit; keys are then ignored until a fresh start.
    step(0, '0, 0, '0, 0, 1);
    start(16'h5678);
    for (int t = 0; t < MT; t++) begin
      guess4(16'h0000); idle(2);
    end
    chk("tp_lose", 16'(o_lose), 16'd1);
    key(4'd1); key(4'd2);
    start(16'h1111);
    chk("tp_restart_attempts", 16'(o_attempts), 16'd0);
    // Clear mid-entry, then clear colliding with a digit strobe.
    key(4'd1); key(4'd2); step(0, '0, 0, '0, 1, 0); guess4(16'h9876); idle(2);
    key(4'd3); step(0, '0, 1, 4'd5, 1, 0);
    // Illegal key, then a key strobe while waiting on the checker.
    key(4'hA); guess4(16'h1112); key(4'd7); idle(2);
    // Reset while waiting on the checker.
    guess4(16'h1111); step(0, '0, 0, '0, 0, 1); idle(2);

    for (int n = 0; n < 3000; n++) begin
      bit          st = 0, dv = 0, clr = 0, rst;
      logic [3:0]  d = '0;
      logic [15:0] sec = '0;
      int          p;
      static bit   cheat = 0;
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) sec[i*4 +: 4] = 4'($urandom_range(0, 9));
      p = int'($urandom_range(0, 99));
      if (!m_round_on) begin
        st = ($urandom_range(0, 2) == 0);
        dv = (p < 30);
        d = 4'($urandom_range(0, 9));
      end else begin
        st = ($urandom_range(0, 19) == 0);
        if (m_count == 0) cheat = ($urandom_range(0, 2) == 0);
        if (p < 75) begin
          dv = 1;
          if (cheat && m_count < 4) d = m_secret[(3 - m_count)*4 +: 4];
          else if ($urandom_range(0, 11) == 0) d = 4'($urandom_range(10, 15));
          else d = 4'($urandom_range(0, 9));
        end else if (p < 82) begin
          clr = 1;
        end else if (p < 85) begin
          clr = 1; dv = 1; d = 4'($urandom_range(0, 9));
        end
      end
      step(st, sec, dv, d, clr, rst);
    end
    idle(4);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
